eco32f_dwb_buffer: RTL

Posted-write buffer on the data-side Wishbone path, directly downstream of the load/store unit's `dwbm_*` master port and upstream of the system bus. It acknowledges stores as soon as they are queued, so the memory stage does not stall for bus write latency. Queued writes drain to the bus in order. Reads (single or wrap-8 refill bursts) are held until the queue is empty, then passed through unmodified, so no read can overtake an older store.

---
 rtl/eco32f_dwb_buffer_pkg.sv | 30 +++
 rtl/eco32f_sync_fifo.sv | 57 +++++
 rtl/eco32f_dwb_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/eco32f_dwb_buffer_pkg.sv
// Shared definitions for the data-side Wishbone posted-write buffer.
// Holds the Wishbone cycle-type / burst-type codes, the buffer FSM state
// encoding and the layout of one queued write entry.
package eco32f_dwb_buffer_pkg;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wishbone burst type extensions
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;

  // Width of one queued write: 32 adr + 32 dat + 4 sel
  localparam int ENTRY_W = 68;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_PASS  = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_entry_t;

endpackage

// File: rtl/eco32f_sync_fifo.sv
// Synchronous FIFO holding posted writes.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write one entry (caller guarantees !full)
//   pop              : discard the head entry (caller guarantees !empty)
//   head             : oldest entry, read straight from the storage registers
//   full, empty      : occupancy flags
//   count            : occupancy, DEPTH_LOG2+1 bits so a full queue is representable
module eco32f_sync_fifo #(
  parameter int WIDTH      = 68,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // Storage is data only; it needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  // count never exceeds DEPTH, so its MSB alone means full.
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);

endmodule

// File: rtl/eco32f_dwb_buffer.sv
// Posted-write buffer between the LSU data Wishbone master and the system bus.
// Stores are acknowledged as soon as they are queued and drained in order;
// reads wait until the queue is empty and then pass straight through.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   s_* inputs / outputs  : slave side facing the LSU master
//   m_* outputs / inputs  : master side facing the system bus
//   buf_empty             : registered, high only in IDLE with nothing queued
//   wr_err, wr_err_adr    : one-cycle pulse and sticky address of a failed posted write
//   dbg_state             : current FSM state
//
// Handshake: a slave request is a cycle with s_cyc_i & s_stb_i. A write is
// taken on the edge where it is requested, s_ack_o is low and the queue has
// room; s_ack_o then pulses for exactly the next cycle. A request that is not
// taken stays pending with no ack. A drained write is complete on the first
// edge where m_ack_i or m_err_i is seen with m_stb_o high; m_rty_i instead
// drops the cycle for one clock and the same entry is reissued.
module eco32f_dwb_buffer
  import eco32f_dwb_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  input  logic        s_we_i,
  input  logic [2:0]  s_cti_i,
  input  logic [1:0]  s_bte_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic        s_rty_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [2:0]  m_cti_o,
  output logic [1:0]  m_bte_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic        buf_empty,
  output logic        wr_err,
  output logic [31:0] wr_err_adr,
  output state_t      dbg_state
);

  state_t            state;
  logic              s_ack_q;
  logic              m_cyc_q;
  logic [31:0]       m_adr_q;
  logic [31:0]       m_dat_q;
  logic [3:0]        m_sel_q;
  logic              buf_empty_q;
  logic              wr_err_q;
  logic [31:0]       wr_err_adr_q;

  wr_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DEPTH_LOG2:0] count;
  logic [DEPTH_LOG2:0] count_nxt;

  logic              in_pass;
  logic              rd_req;
  logic              push;
  logic              pop;
  logic              empty_nxt;

  assign in_pass = (state == ST_PASS);
  assign rd_req  = s_cyc_i & s_stb_i & ~s_we_i;
  // s_ack_q guard stops a second push while the LSU still holds stb in the ack cycle.
  assign push    = s_cyc_i & s_stb_i & s_we_i & ~s_ack_q & ~fifo_full & ~in_pass;
  assign pop     = (state == ST_DRAIN) & m_cyc_q & (m_ack_i | m_err_i);

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + (DEPTH_LOG2+1)'(1);
    if (pop && !push) count_nxt = count - (DEPTH_LOG2+1)'(1);
  end
  assign empty_nxt = (count_nxt == '0);

  eco32f_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({s_adr_i, s_dat_i, s_sel_i}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // buf_empty_q is cleared by default and only set on paths that land in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_ack_q      <= 1'b0;
      m_cyc_q      <= 1'b0;
      m_adr_q      <= '0;
      m_dat_q      <= '0;
      m_sel_q      <= '0;
      buf_empty_q  <= 1'b1;
      wr_err_q     <= 1'b0;
      wr_err_adr_q <= '0;
    end else begin
      s_ack_q     <= push;
      wr_err_q    <= 1'b0;
      buf_empty_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_req && fifo_empty) begin
            state <= ST_PASS;
          end else if (!fifo_empty) begin
            state   <= ST_DRAIN;
            m_cyc_q <= 1'b1;
            m_adr_q <= head.adr;
            m_dat_q <= head.dat;
            m_sel_q <= head.sel;
          end else begin
            buf_empty_q <= empty_nxt;
          end
        end
        ST_DRAIN: begin
          if (m_cyc_q) begin
            if (m_ack_i || m_err_i) begin
              m_cyc_q     <= 1'b0;
              state       <= ST_IDLE;
              buf_empty_q <= empty_nxt;
              if (!m_ack_i) begin
                wr_err_q     <= 1'b1;
                wr_err_adr_q <= m_adr_q;
              end
            end else if (m_rty_i) begin
              // One dead cycle, then the same head entry goes out again.
              m_cyc_q <= 1'b0;
            end
          end else begin
            m_cyc_q <= 1'b1;
          end
        end
        ST_PASS: begin
          if (!s_cyc_i) begin
            state       <= ST_IDLE;
            buf_empty_q <= empty_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In PASS the bus is wired straight through; otherwise outputs come from registers.
  assign s_ack_o    = in_pass ? m_ack_i : s_ack_q;
  assign s_err_o    = in_pass & m_err_i;
  assign s_rty_o    = in_pass & m_rty_i;
  assign s_dat_o    = in_pass ? m_dat_i : 32'h0;

  assign m_adr_o    = in_pass ? s_adr_i : m_adr_q;
  assign m_dat_o    = in_pass ? s_dat_i : m_dat_q;
  assign m_sel_o    = in_pass ? s_sel_i : m_sel_q;
  assign m_cyc_o    = in_pass ? s_cyc_i : m_cyc_q;
  assign m_stb_o    = in_pass ? s_stb_i : m_cyc_q;
  assign m_we_o     = in_pass ? s_we_i  : m_cyc_q;
  assign m_cti_o    = in_pass ? s_cti_i : (m_cyc_q ? CTI_EOB : CTI_CLASSIC);
  assign m_bte_o    = in_pass ? s_bte_i : BTE_LINEAR;

  assign buf_empty  = buf_empty_q;
  assign wr_err     = wr_err_q;
  assign wr_err_adr = wr_err_adr_q;
  assign dbg_state  = state;

endmodule
